bitwise_seq_unit: RTL and testbench
===================================

BITWISE_SEQ_UNIT -- requirements
Module: bitwise_seq_unit

Interface
REQ-001 Parameter BUS_WIDTH, default 8, operand/result width; SHALL be a power of two, >= 4.
REQ-002 Parameter INST_WIDTH, default 4, opcode width; SHALL be 4.
REQ-003 Local SHAMT_W = clog2(BUS_WIDTH); shift amount = B[SHAMT_W-1:0].
REQ-004 Ports SHALL be, in order:
- clk  input  1  sole clock, rising edge; one clock; reset is synchronous and active-high.
- rst  input  1  synchronous active-high reset.
- A  input  BUS_WIDTH  operand A.
- B  input  BUS_WIDTH  operand B / shift amount.
- inst  input  INST_WIDTH  opcode.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready at a rising edge.
- Y  output  BUS_WIDTH  registered result.
- out_valid  output  1  Y valid.
- out_ready  input  1  consumer takes Y.
- zero  output  1  Y == 0.
- parity  output  1  XOR-reduction of Y.
- carry  output  1  last bit shifted out.

Function
REQ-005 inst[3]=0 logic ops by inst[1:0]: 0 A&B, 1 A|B, 2 A^B, 3 NOT (inst[2]=0: ~A, 1: ~B).
REQ-006 inst[3]=1 shift ops by inst[1:0]: 0 SHL logical, 1 SHR (inst[2]=1 arithmetic, 0 logical), 2 ROL, 3 ROR; inst[2] ignored except for SHR.
REQ-007 FSM states IDLE, SHIFT; in_ready = !rst && state==IDLE && (!out_valid || out_ready).
REQ-008 Logic op or shift with amount 0 accepted at edge E0: Y, flags registered and out_valid=1 at E0; state stays IDLE.
REQ-009 Shift with amount n>0 accepted at E0: operand and counter=n loaded, state->SHIFT; one bit position per subsequent edge; at edge E0+n Y loaded, out_valid=1, state->IDLE.
REQ-010 Operands and opcode sampled only on accept; input changes afterwards SHALL NOT affect the result.
REQ-011 out_valid && !out_ready: Y, flags, out_valid held stable; no new accept.
REQ-012 out_valid && out_ready without accept: out_valid->0 next edge, Y holds last value.
REQ-013 Simultaneous output handshake and new accept at same edge: new result/ state replaces old per REQ-008/009; out_valid stays 1 only if REQ-008 applies, else falls to 0.
REQ-014 out_ready while in SHIFT has no effect; in_valid while not ready ignored.
REQ-015 Arithmetic SHR replicates sign bit; rotates lose no bits; amount range 0..BUS_WIDTH-1 only.
REQ-016 carry = last bit shifted/rotated out; 0 for logic ops and amount 0.

Reset
REQ-017 rst high at an edge: state IDLE, counter 0, Y 0, out_valid 0, zero/parity/carry 0; in_ready 0 while rst high.
REQ-018 rst mid-SHIFT aborts the operation; no out_valid produced for it.
REQ-019 First accept possible at first edge with rst low.

Configuration
REQ-020 Macro BITWISE_FLAGS_EN defined: zero, parity, carry computed per REQ-004/016, registered with Y.
REQ-021 Macro undefined: flag ports present, constant 0; no flag logic; data and timing unchanged.

Verification (BUS_WIDTH=8, BITWISE_FLAGS_EN defined unless noted)
REQ-022 AND: A=0xCA, B=0x0F, inst=0x0 -> at E0 Y=0x0A, out_valid=1, zero=0, parity=0, carry=0.
REQ-023 NOT B: A=0x00, B=0x5A, inst=0x7 -> Y=0xA5 at E0; then inst=0x0, A=0x00 -> Y=0x00, zero=1.
REQ-024 SAR: A=0x94, B=0x03, inst=0xD -> in_ready=0 for E0+1..E0+3, out_valid at E0+3, Y=0xF2, carry=1; ROR A=0x81, B=0x01, inst=0xB -> Y=0xC0, carry=1 at E0+1.
REQ-025 Backpressure: out_ready=0 for 5 cycles after REQ-022 result -> Y, out_valid stable, in_ready=0; out_ready=1 with new in_valid -> back-to-back accept, out_valid continuous.
REQ-026 Reset mid-shift: SHL A=0x01, B=0x07, rst at E0+3 -> out_valid stays 0, Y=0x00, in_ready=1 first edge after rst low.
REQ-027 BITWISE_FLAGS_EN undefined: rerun REQ-024 -> identical Y/timing, carry=zero=parity=0.

Source files
------------

// File: rtl/bitwise_seq_unit.sv
// Bitwise logic / bit-serial shift unit with valid-ready handshakes on both sides.
// Optional flag outputs (zero, parity, carry) are built only when BITWISE_FLAGS_EN is defined.
module bitwise_seq_unit #(
  parameter int BUS_WIDTH  = 8,
  parameter int INST_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUS_WIDTH-1:0]  A,
  input  logic [BUS_WIDTH-1:0]  B,
  input  logic [INST_WIDTH-1:0] inst,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BUS_WIDTH-1:0]  Y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  zero,
  output logic                  parity,
  output logic                  carry
);

  localparam int SHAMT_W = $clog2(BUS_WIDTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [SHAMT_W-1:0]     cnt_r;
  logic [BUS_WIDTH-1:0]   op_r;
  logic [2:0]             opc_r;
  logic [BUS_WIDTH-1:0]   y_r;
  logic                   out_valid_r;
  logic                   in_ready_s;
  logic                   accept_s;
  logic                   immediate_s;
  logic                   last_step_s;
  logic [SHAMT_W-1:0]     shamt_s;
  logic [BUS_WIDTH-1:0]   step_s;
  logic                   load_y_s;
  logic [BUS_WIDTH-1:0]   y_nxt_s;

  function automatic logic [BUS_WIDTH-1:0] logic_op(input logic [BUS_WIDTH-1:0] a,
                                                    input logic [BUS_WIDTH-1:0] b,
                                                    input logic [2:0]           op);
    case (op[1:0])
      2'd0:    logic_op = a & b;
      2'd1:    logic_op = a | b;
      2'd2:    logic_op = a ^ b;
      2'd3:    logic_op = op[2] ? ~b : ~a;
      default: logic_op = {BUS_WIDTH{1'b0}};
    endcase
  endfunction

  // One bit position of SHL / SHR / ROL / ROR; op[2] selects arithmetic SHR.
  function automatic logic [BUS_WIDTH-1:0] shift_step(input logic [BUS_WIDTH-1:0] v,
                                                      input logic [2:0]           op);
    case (op[1:0])
      2'd0:    shift_step = {v[BUS_WIDTH-2:0], 1'b0};
      2'd1:    shift_step = {op[2] & v[BUS_WIDTH-1], v[BUS_WIDTH-1:1]};
      2'd2:    shift_step = {v[BUS_WIDTH-2:0], v[BUS_WIDTH-1]};
      2'd3:    shift_step = {v[0], v[BUS_WIDTH-1:1]};
      default: shift_step = v;
    endcase
  endfunction

  function automatic logic step_carry(input logic [BUS_WIDTH-1:0] v, input logic [2:0] op);
    step_carry = op[0] ? v[0] : v[BUS_WIDTH-1];
  endfunction

  function automatic logic parity_of(input logic [BUS_WIDTH-1:0] v);
    parity_of = ^v;
  endfunction

  assign shamt_s     = B[SHAMT_W-1:0];
  assign immediate_s = !inst[3] || (shamt_s == {SHAMT_W{1'b0}});
  assign in_ready_s  = !rst && (state_r == IDLE) && (!out_valid_r || out_ready);
  assign accept_s    = in_valid && in_ready_s;
  assign last_step_s = (cnt_r <= SHAMT_W'(1));
  assign step_s      = shift_step(op_r, opc_r);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !immediate_s) state_nxt_s = SHIFT;
        else                          state_nxt_s = IDLE;
      end
      SHIFT: begin
        if (last_step_s) state_nxt_s = IDLE;
        else             state_nxt_s = SHIFT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Result selection: immediate ops load on accept, shifts on their final step
  always_comb begin
    load_y_s = 1'b0;
    y_nxt_s  = y_r;
    if (accept_s && immediate_s) begin
      load_y_s = 1'b1;
      y_nxt_s  = inst[3] ? A : logic_op(A, B, inst[2:0]);
    end else if ((state_r == SHIFT) && last_step_s) begin
      load_y_s = 1'b1;
      y_nxt_s  = step_s;
    end else begin
      load_y_s = 1'b0;
      y_nxt_s  = y_r;
    end
  end

  // Datapath registers: result, output valid, shift operand and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r         <= {BUS_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      op_r        <= {BUS_WIDTH{1'b0}};
      opc_r       <= 3'b000;
      cnt_r       <= {SHAMT_W{1'b0}};
    end else begin
      if (load_y_s) begin
        y_r <= y_nxt_s;
      end
      // A shift accept also retires any result being handed off at this edge.
      if (load_y_s) begin
        out_valid_r <= 1'b1;
      end else if (accept_s || out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (accept_s && !immediate_s) begin
        op_r  <= A;
        opc_r <= inst[2:0];
        cnt_r <= shamt_s;
      end else if (state_r == SHIFT) begin
        op_r  <= step_s;
        cnt_r <= cnt_r - SHAMT_W'(1);
      end
    end
  end

`ifdef BITWISE_FLAGS_EN
  logic zero_r;
  logic parity_r;
  logic carry_r;
  logic carry_nxt_s;

  // Carry comes only from the final step of a non-zero shift
  always_comb begin
    carry_nxt_s = 1'b0;
    if ((state_r == SHIFT) && last_step_s) begin
      carry_nxt_s = step_carry(op_r, opc_r);
    end else begin
      carry_nxt_s = 1'b0;
    end
  end

  // Flags registered together with Y
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_r   <= 1'b0;
      parity_r <= 1'b0;
      carry_r  <= 1'b0;
    end else if (load_y_s) begin
      zero_r   <= (y_nxt_s == {BUS_WIDTH{1'b0}});
      parity_r <= parity_of(y_nxt_s);
      carry_r  <= carry_nxt_s;
    end
  end

  assign zero   = zero_r;
  assign parity = parity_r;
  assign carry  = carry_r;
`else
  assign zero   = 1'b0;
  assign parity = 1'b0;
  assign carry  = 1'b0;
`endif

  assign in_ready  = in_ready_s;
  assign Y         = y_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_bitwise_seq_unit.sv
// Directed self-checking bench for bitwise_seq_unit (BUS_WIDTH=8); flag expectations
// follow BITWISE_FLAGS_EN as seen by the bench.
module tb_bitwise_seq_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic [3:0] inst = 4'h0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] Y;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       zero;
  logic       parity;
  logic       carry;

  int vectors = 0;
  int miscompares = 0;

`ifdef BITWISE_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  bitwise_seq_unit #(.BUS_WIDTH(8), .INST_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .inst(inst),
    .in_valid(in_valid), .in_ready(in_ready),
    .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
    .zero(zero), .parity(parity), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; A = 8'hFF; B = 8'hFF; inst = 4'h1;
    tick(); tick();
    vectors++; if (Y !== 8'h00) begin miscompares++; $display("FAIL rst_y: got %h expected %h", Y, 8'h00); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    vectors++; if ({zero, parity, carry} !== 3'b000) begin miscompares++; $display("FAIL rst_flags: got %b expected 000", {zero, parity, carry}); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    in_valid = 1'b0; rst = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_and();
    A = 8'hCA; B = 8'h0F; inst = 4'h0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if (Y !== 8'h0A) begin miscompares++; $display("FAIL and_y: got %h expected %h", Y, 8'h0A); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL and_out_valid: got %b expected 1", out_valid); end
    vectors++; if ({zero, parity, carry} !== 3'b000) begin miscompares++; $display("FAIL and_flags: got %b expected 000", {zero, parity, carry}); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL and_drain_valid: got %b expected 0", out_valid); end
    vectors++; if (Y !== 8'h0A) begin miscompares++; $display("FAIL and_drain_y: got %h expected %h", Y, 8'h0A); end
  endtask

  task automatic test_not();
    A = 8'h00; B = 8'h5A; inst = 4'h7; in_valid = 1'b1;
    tick();
    vectors++; if (Y !== 8'hA5) begin miscompares++; $display("FAIL notb_y: got %h expected %h", Y, 8'hA5); end
    vectors++; if (zero !== 1'b0) begin miscompares++; $display("FAIL notb_zero: got %b expected 0", zero); end
    A = 8'h00; inst = 4'h0;
    tick();
    in_valid = 1'b0;
    vectors++; if (Y !== 8'h00) begin miscompares++; $display("FAIL and_zero_y: got %h expected %h", Y, 8'h00); end
    vectors++; if (zero !== FL) begin miscompares++; $display("FAIL and_zero_flag: got %b expected %b", zero, FL); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL and_zero_valid: got %b expected 1", out_valid); end
    tick();
  endtask

  task automatic test_shift();
    A = 8'h94; B = 8'h03; inst = 4'hD; in_valid = 1'b1;
    tick();
    A = 8'hFF; B = 8'h01; inst = 4'h0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL sar_busy_ready[%0d]: got %b expected 0", i, in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sar_busy_valid[%0d]: got %b expected 0", i, out_valid); end
      if (i == 2) in_valid = 1'b0;
      tick();
    end
    vectors++; if (Y !== 8'hF2) begin miscompares++; $display("FAIL sar_y: got %h expected %h", Y, 8'hF2); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sar_valid: got %b expected 1", out_valid); end
    vectors++; if ({zero, parity, carry} !== {1'b0, FL, FL}) begin miscompares++; $display("FAIL sar_flags: got %b expected %b", {zero, parity, carry}, {1'b0, FL, FL}); end
    A = 8'h81; B = 8'h01; inst = 4'hB; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ror_accept_valid: got %b expected 0", out_valid); end
    tick();
    vectors++; if (Y !== 8'hC0) begin miscompares++; $display("FAIL ror_y: got %h expected %h", Y, 8'hC0); end
    vectors++; if ({out_valid, carry, parity} !== {1'b1, FL, 1'b0}) begin miscompares++; $display("FAIL ror_valid_carry_parity: got %b expected %b", {out_valid, carry, parity}, {1'b1, FL, 1'b0}); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    A = 8'hCA; B = 8'h0F; inst = 4'h0; in_valid = 1'b1;
    tick();
    A = 8'hFF; B = 8'hFF; inst = 4'h1;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (Y !== 8'h0A) begin miscompares++; $display("FAIL bp_y[%0d]: got %h expected %h", i, Y, 8'h0A); end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, in_ready); end
      tick();
    end
    out_ready = 1'b1; A = 8'hF0; B = 8'h0C; inst = 4'h1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    tick();
    vectors++; if ({out_valid, Y} !== {1'b1, 8'hFC}) begin miscompares++; $display("FAIL b2b_or: got %b/%h expected 1/%h", out_valid, Y, 8'hFC); end
    A = 8'hFF; B = 8'h0F; inst = 4'h2;
    tick();
    in_valid = 1'b0;
    vectors++; if ({out_valid, Y} !== {1'b1, 8'hF0}) begin miscompares++; $display("FAIL b2b_xor: got %b/%h expected 1/%h", out_valid, Y, 8'hF0); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_shift();
    A = 8'h01; B = 8'h07; inst = 4'h8; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    vectors++; if ({out_valid, Y} !== {1'b0, 8'h00}) begin miscompares++; $display("FAIL rstshift_state: got %b/%h expected 0/%h", out_valid, Y, 8'h00); end
    rst = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstshift_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 6; i++) tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstshift_no_result: got %b expected 0", out_valid); end
  endtask

  task automatic test_shift_bounds();
    A = 8'h01; B = 8'h07; inst = 4'h8; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL shl7_early: got %b expected 0", out_valid); end
    tick();
    vectors++; if ({out_valid, Y} !== {1'b1, 8'h80}) begin miscompares++; $display("FAIL shl7_result: got %b/%h expected 1/%h", out_valid, Y, 8'h80); end
    vectors++; if ({carry, parity} !== {1'b0, FL}) begin miscompares++; $display("FAIL shl7_flags: got %b expected %b", {carry, parity}, {1'b0, FL}); end
    A = 8'h5A; B = 8'h08; inst = 4'h9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if ({out_valid, Y, carry} !== {1'b1, 8'h5A, 1'b0}) begin miscompares++; $display("FAIL shamt0: got %b/%h/%b expected 1/%h/0", out_valid, Y, carry, 8'h5A); end
    A = 8'h80; B = 8'h07; inst = 4'h9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    vectors++; if ({out_valid, Y, carry} !== {1'b1, 8'h01, 1'b0}) begin miscompares++; $display("FAIL shr7_logical: got %b/%h/%b expected 1/%h/0", out_valid, Y, carry, 8'h01); end
    A = 8'hC3; B = 8'h01; inst = 4'hC; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    vectors++; if ({out_valid, Y} !== {1'b1, 8'h86}) begin miscompares++; $display("FAIL shl_inst2_y: got %b/%h expected 1/%h", out_valid, Y, 8'h86); end
    vectors++; if ({carry, parity} !== {FL, FL}) begin miscompares++; $display("FAIL shl_inst2_flags: got %b expected %b", {carry, parity}, {FL, FL}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_and();
    test_not();
    test_shift();
    test_back_to_back();
    test_reset_mid_shift();
    test_shift_bounds();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
